// File: rtl/uart_rx_fifo.sv
// Receives UART receiver level flags into clk events; buffers good bytes in an FWFT FIFO and counts errors.
// Latency 3 clk edges from Rx_VALID rising to empty=0; no backpressure: a byte arriving while full is dropped and overflow latches.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        Rx_DATA,
  input  logic              Rx_VALID,
  input  logic              Rx_FERROR,
  input  logic              Rx_PERROR,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [CNT_W-1:0]  ferr_count,
  output logic [CNT_W-1:0]  perr_count,
  input  logic              clr_status
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  // bit 0 valid, bit 1 frame error, bit 2 parity error
  logic [2:0] sync1, sync2, prev, edge_vld;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              push_vld, ferr_vld, perr_vld;
  logic              push_ok, pop_ok, drop_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {Rx_PERROR, Rx_FERROR, Rx_VALID};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_vld = sync2 & ~prev;
  assign push_vld = edge_vld[0];
  assign ferr_vld = edge_vld[1];
  assign perr_vld = edge_vld[2];

  // A pop frees the slot the simultaneous push needs, so full only blocks an unaccompanied push.
  assign pop_ok   = rd_en & ~empty;
  assign push_ok  = push_vld & (~full | pop_ok);
  assign drop_vld = push_vld & full & ~pop_ok;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + (ADDR_W+1)'(1);
      2'b01:   count_nxt = count - (ADDR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= Rx_DATA;
  end

  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  // An event coinciding with clr_status wins for its own counter or flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      ferr_count <= '0;
      perr_count <= '0;
    end else begin
      if (drop_vld)        overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;

      if (ferr_vld) begin
        if (clr_status)        ferr_count <= CNT_W'(1);
        else if (~&ferr_count) ferr_count <= ferr_count + CNT_W'(1);
      end else if (clr_status) begin
        ferr_count <= '0;
      end

      if (perr_vld) begin
        if (clr_status)        perr_count <= CNT_W'(1);
        else if (~&perr_count) perr_count <= perr_count + CNT_W'(1);
      end else if (clr_status) begin
        perr_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk, reset;
  logic [7:0]       Rx_DATA;
  logic             Rx_VALID, Rx_FERROR, Rx_PERROR;
  logic             rd_en, clr_status;
  logic [7:0]       rd_data;
  logic             empty, full, overflow;
  logic [ADDR_W:0]  count;
  logic [CNT_W-1:0] ferr_count, perr_count;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
    .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .ferr_count(ferr_count), .perr_count(perr_count),
    .clr_status(clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // reference model
  logic [7:0] q[$];
  logic       m_ovf;
  int         m_ferr, m_perr;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic model_push(input logic [7:0] b);
    if (q.size() == DEPTH) m_ovf = 1'b1;
    else q.push_back(b);
  endtask

  // kind 0 = valid byte, 1 = frame error, 2 = parity error; called and returns at a negedge
  task automatic pulse(input int kind, input logic [7:0] b, input int hi);
    Rx_DATA = b;
    case (kind)
      0:       Rx_VALID  = 1'b1;
      1:       Rx_FERROR = 1'b1;
      default: Rx_PERROR = 1'b1;
    endcase
    repeat (hi) @(negedge clk);
    Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
    repeat (4) @(negedge clk);
    case (kind)
      0:       model_push(b);
      1:       if (m_ferr < CMAX) m_ferr++;
      default: if (m_perr < CMAX) m_perr++;
    endcase
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clear_status();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    m_ovf = 1'b0; m_ferr = 0; m_perr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Rx_DATA = 8'h00; Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
    rd_en = 1'b0; clr_status = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    q.delete(); m_ovf = 1'b0; m_ferr = 0; m_perr = 0;
    repeat (5) @(negedge clk);
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else passed++;
    total++; if (count !== '0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else passed++;
    total++; if (ferr_count !== '0) $display("FAIL reset_ferr got=%0d exp=0", ferr_count); else passed++;
    total++; if (perr_count !== '0) $display("FAIL reset_perr got=%0d exp=0", perr_count); else passed++;
    total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", rd_data); else passed++;
  endtask

  task automatic test_single_push();
    Rx_DATA = 8'hA5; Rx_VALID = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (empty !== 1'b1) $display("FAIL latency_edge2_empty got=%b exp=1", empty); else passed++;
    @(negedge clk);
    total++; if (count !== 4'd1) $display("FAIL latency_edge3_count got=%0d exp=1", count); else passed++;
    total++; if (rd_data !== 8'hA5) $display("FAIL single_rd_data got=%h exp=a5", rd_data); else passed++;
    repeat (17) @(negedge clk);
    Rx_VALID = 1'b0;
    repeat (4) @(negedge clk);
    q.push_back(8'hA5);
    total++; if (count !== 4'(q.size())) $display("FAIL single_one_push got=%0d exp=%0d", count, q.size()); else passed++;
    pop();
    total++; if (empty !== 1'b1) $display("FAIL single_pop_empty got=%b exp=1", empty); else passed++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DEPTH; i++) pulse(0, 8'(i), 3);
    total++; if (full !== 1'b1) $display("FAIL fill_full got=%b exp=1", full); else passed++;
    total++; if (count !== 4'(DEPTH)) $display("FAIL fill_count got=%0d exp=%0d", count, DEPTH); else passed++;
    pulse(0, 8'h09, 3);
    total++; if (overflow !== m_ovf) $display("FAIL ovf_flag got=%b exp=%b", overflow, m_ovf); else passed++;
    total++; if (count !== 4'(q.size())) $display("FAIL ovf_count got=%0d exp=%0d", count, q.size()); else passed++;
    for (int i = 1; i <= DEPTH; i++) begin
      total++; if (rd_data !== 8'(i)) $display("FAIL drain_order got=%h exp=%h", rd_data, 8'(i)); else passed++;
      pop();
    end
    total++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else passed++;
    pulse(0, 8'h0A, 3);
    total++; if (rd_data !== 8'h0A) $display("FAIL wrap_rd_data got=%h exp=0a", rd_data); else passed++;
    pop();
  endtask

  task automatic test_full_push_pop();
    clear_status();
    total++; if (overflow !== 1'b0) $display("FAIL clr_overflow got=%b exp=0", overflow); else passed++;
    for (int i = 0; i < DEPTH; i++) pulse(0, 8'h11 + 8'(i), 2);
    total++; if (rd_data !== 8'h11) $display("FAIL fullpp_head got=%h exp=11", rd_data); else passed++;
    Rx_DATA = 8'h55; Rx_VALID = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; Rx_VALID = 1'b0;
    void'(q.pop_front()); q.push_back(8'h55);
    repeat (3) @(negedge clk);
    total++; if (overflow !== 1'b0) $display("FAIL fullpp_overflow got=%b exp=0", overflow); else passed++;
    total++; if (count !== 4'(DEPTH)) $display("FAIL fullpp_count got=%0d exp=%0d", count, DEPTH); else passed++;
    while (q.size() > 0) begin
      total++; if (rd_data !== q[0]) $display("FAIL fullpp_order got=%h exp=%h", rd_data, q[0]); else passed++;
      pop();
    end
    total++; if (empty !== 1'b1) $display("FAIL fullpp_empty got=%b exp=1", empty); else passed++;
  endtask

  task automatic test_err_counters();
    for (int i = 0; i < 3; i++) pulse(1, 8'h00, 20);
    pulse(2, 8'h00, 20);
    total++; if (ferr_count !== CNT_W'(m_ferr)) $display("FAIL err_ferr got=%0d exp=%0d", ferr_count, m_ferr); else passed++;
    total++; if (perr_count !== CNT_W'(m_perr)) $display("FAIL err_perr got=%0d exp=%0d", perr_count, m_perr); else passed++;
    total++; if (count !== 4'd0) $display("FAIL err_no_write got=%0d exp=0", count); else passed++;
    for (int i = 0; i < CMAX + 3; i++) pulse(2, 8'h00, 1);
    total++; if (perr_count !== CNT_W'(m_perr)) $display("FAIL err_saturate got=%0d exp=%0d", perr_count, m_perr); else passed++;
  endtask

  task automatic test_clr_coincident();
    clear_status();
    total++; if (perr_count !== '0) $display("FAIL clr_perr got=%0d exp=0", perr_count); else passed++;
    for (int i = 0; i < 5; i++) pulse(1, 8'h00, 2);
    total++; if (ferr_count !== 8'd5) $display("FAIL clr_pre_ferr got=%0d exp=5", ferr_count); else passed++;
    Rx_FERROR = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0; Rx_FERROR = 1'b0;
    m_ferr = 1; m_perr = 0; m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ferr_count !== CNT_W'(m_ferr)) $display("FAIL clr_coincident_ferr got=%0d exp=%0d", ferr_count, m_ferr); else passed++;
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 5);
      if (op <= 2) pulse(0, 8'($urandom), $urandom_range(1, 4));
      else if (op == 3) pulse($urandom_range(1, 2), 8'($urandom), $urandom_range(1, 4));
      else begin
        if (q.size() > 0) begin
          total++; if (rd_data !== q[0]) $display("FAIL rand_rd_data i=%0d got=%h exp=%h", i, rd_data, q[0]); else passed++;
        end
        pop();
      end
      total++; if (count !== 4'(q.size())) $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, count, q.size()); else passed++;
      total++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH))
        $display("FAIL rand_flags i=%0d got empty=%b full=%b exp size=%0d", i, empty, full, q.size()); else passed++;
      total++; if (overflow !== m_ovf) $display("FAIL rand_overflow i=%0d got=%b exp=%b", i, overflow, m_ovf); else passed++;
      total++; if (ferr_count !== CNT_W'(m_ferr) || perr_count !== CNT_W'(m_perr))
        $display("FAIL rand_errs i=%0d got=%0d/%0d exp=%0d/%0d", i, ferr_count, perr_count, m_ferr, m_perr); else passed++;
    end
  endtask

  task automatic test_reset_midburst();
    while (q.size() > 0) pop();
    for (int i = 0; i < 4; i++) pulse(0, 8'hC0 + 8'(i), 2);
    total++; if (count !== 4'd4) $display("FAIL mid_pre_count got=%0d exp=4", count); else passed++;
    Rx_DATA = 8'hEE; Rx_VALID = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0)
      $display("FAIL mid_fifo got count=%0d empty=%b full=%b exp 0/1/0", count, empty, full); else passed++;
    total++; if (overflow !== 1'b0 || ferr_count !== '0 || perr_count !== '0 || rd_data !== 8'h00)
      $display("FAIL mid_status got ovf=%b ferr=%0d perr=%0d rd=%h exp 0", overflow, ferr_count, perr_count, rd_data); else passed++;
    Rx_VALID = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    q.delete(); m_ovf = 1'b0; m_ferr = 0; m_perr = 0;
    repeat (5) @(negedge clk);
    total++; if (empty !== 1'b1) $display("FAIL mid_post_empty got=%b exp=1", empty); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_full_push_pop();
    test_err_counters();
    test_clr_coincident();
    test_random();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Downstream consumer of the UART receiver. Runs on the system clock and turns the receiver's Rx_VALID / Rx_FERROR / Rx_PERROR level flags, which come from the Rx_sample domain, into single-cycle events.
- Buffers good bytes in a first-word-fall-through FIFO with a pop handshake.
- Keeps saturating frame-error and parity-error counters, plus a sticky overflow flag, for status readout.

Parameters:
DEPTH, 8, number of FIFO entries; must be a power of two and at least 2
ADDR_W, 3, log2(DEPTH)
CNT_W, 8, width of each error counter

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
Rx_DATA  input  8  received byte from the receiver; stable while Rx_VALID is high
Rx_VALID  input  1  receiver valid level; high for one full bit period per good byte
Rx_FERROR  input  1  receiver frame-error level
Rx_PERROR  input  1  receiver parity-error level
rd_en  input  1  pop request; honoured only when empty=0
rd_data  output  8  head-of-FIFO byte; meaningful only when empty=0
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  ADDR_W+1  current number of entries, 0..DEPTH
overflow  output  1  sticky: a byte was dropped because the FIFO was full
ferr_count  output  CNT_W  frame-error events, saturating
perr_count  output  CNT_W  parity-error events, saturating
clr_status  input  1  synchronous clear of overflow, ferr_count and perr_count

Behaviour:
- Reset (reset=1 at a clk edge):
  - FIFO pointers and count go to 0; empty=1, full=0.
  - overflow=0, ferr_count=0, perr_count=0, rd_data=0.
  - All synchronizer and edge flops go to 0.
  - Reset dominates every other input, including in the middle of a write or pop. Memory contents are don't-care.
- Synchronization:
  - Each of Rx_VALID, Rx_FERROR and Rx_PERROR passes through a 2-flop synchronizer, then a third "previous" flop.
  - An event is synced=1 and prev=0, i.e. one clk pulse per rising edge.
  - A level held high produces exactly one event.
- Write:
  - On a valid event, Rx_DATA is captured directly (not synchronized) in the same cycle; it is guaranteed stable for the whole Rx_VALID high period.
  - The byte goes to mem[wr_ptr] and wr_ptr increments, wrapping modulo DEPTH.
  - Latency: 3 clk edges from Rx_VALID rising at the input to empty=0, assuming synchronizer setup is met.
- Read:
  - rd_data is mem[rd_ptr], combinational from the registered pointer (FWFT).
  - rd_en=1 with empty=0 increments rd_ptr, wrapping. The next entry appears on rd_data the following cycle.
  - rd_en with empty=1 is ignored: pointers unchanged, no error flag.
- Count, empty and full are registered and updated each cycle:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - empty = (count==0); full = (count==DEPTH)
- Full boundary:
  - A push with full=1 and no pop: byte dropped, pointers and count unchanged, overflow set to 1.
  - A push and pop together while full: both happen, no overflow.
- Empty boundary:
  - A push and pop together while empty: push only; the pop is ignored.
- Error counters:
  - A ferror event increments ferr_count; a perror event increments perr_count. Each saturates at 2^CNT_W-1.
  - An error event does not write the FIFO.
- clr_status:
  - Sets overflow, ferr_count and perr_count to 0. FIFO contents are untouched.
  - If an event coincides with clr_status, the event wins for its own counter or flag: the counter becomes 1, or overflow becomes 1.
- No other state machine: pointers and counters only. Receiver-side protocol is guaranteed by the receiver (Rx_VALID and Rx_FERROR/Rx_PERROR are never high together).

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, overflow=0, ferr_count=0, perr_count=0.
- Rx_DATA=0xA5 with Rx_VALID high for 20 clk -> count=1 after the 3rd edge, rd_data=0xA5, exactly one push. Then rd_en for 1 cycle -> empty=1.
- Push 0x01..0x08 (DEPTH=8) -> full=1, count=8. Push 0x09 -> overflow=1, count=8. Pop 8 times -> reads 0x01..0x08 in order, empty=1. Push 0x0A -> pointer wraparound correct, rd_data=0x0A.
- With full=1, a push of 0x55 coincident with rd_en -> overflow stays 0, count=8, 0x55 becomes the last entry read.
- Three Rx_FERROR pulses and one Rx_PERROR pulse, each high 20 clk -> ferr_count=3, perr_count=1, count=0. With CNT_W=2, five perror pulses -> perr_count=3.
- clr_status asserted in the same cycle as a ferror event with ferr_count=5 -> ferr_count=1.
- reset asserted mid-burst with count=4 -> all outputs return to reset values on the next edge.
